// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 VGA raster timing: pixel tick, X/Y, video-on, frame strobe, syncs.
// Optional VGA_TIMING_RGB_EN adds a registered colour path with sync delayed one pixel to match.
module vga_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       PIXEL_TICK_O,
  output logic [9:0] PIXEL_X_O,
  output logic [9:0] PIXEL_Y_O,
  output logic       VIDEO_ON_O,
  output logic       FRAME_START_O,
  output logic       VGA_H_SYNC_O,
  output logic       VGA_V_SYNC_O
`ifdef VGA_TIMING_RGB_EN
  ,
  input  logic [3:0] RED_I,
  input  logic [3:0] GREEN_I,
  input  logic [3:0] BLUE_I,
  output logic [3:0] VGA_RED_O,
  output logic [3:0] VGA_GREEN_O,
  output logic [3:0] VGA_BLUE_O
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
  logic [9:0]       h_cnt_d, h_cnt_q;
  logic [9:0]       v_cnt_d, v_cnt_q;
  logic             tick;
  logic             pixel_tick_d, pixel_tick_q;
  logic             video_on_d, video_on_q;
  logic             h_sync_d, h_sync_q;
  logic             v_sync_d, v_sync_q;
  logic             frame_start_d, frame_start_q;

  // Decode is taken from the next-state counts so the registered flags line up with X/Y.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
    pixel_tick_d  = tick;
    video_on_d    = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    h_sync_d      = !((h_cnt_d >= H_SYNC_LO) && (h_cnt_d <= H_SYNC_HI));
    v_sync_d      = !((v_cnt_d >= V_SYNC_LO) && (v_cnt_d <= V_SYNC_HI));
    frame_start_d = tick && (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pixel_tick_q  <= 1'b0;
      video_on_q    <= 1'b1;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pixel_tick_q  <= pixel_tick_d;
      video_on_q    <= video_on_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign PIXEL_TICK_O  = pixel_tick_q;
  assign PIXEL_X_O     = h_cnt_q;
  assign PIXEL_Y_O     = v_cnt_q;
  assign VIDEO_ON_O    = video_on_q;
  assign FRAME_START_O = frame_start_q;

`ifdef VGA_TIMING_RGB_EN
  logic [3:0] red_d, red_q;
  logic [3:0] green_d, green_q;
  logic [3:0] blue_d, blue_q;
  logic       h_sync_dly_d, h_sync_dly_q;
  logic       v_sync_dly_d, v_sync_dly_q;

  // Colour for the pixel being displayed is captured at the end of its period; sync follows it.
  always_comb begin
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    h_sync_dly_d = h_sync_dly_q;
    v_sync_dly_d = v_sync_dly_q;
    if (tick) begin
      red_d        = video_on_q ? RED_I   : 4'h0;
      green_d      = video_on_q ? GREEN_I : 4'h0;
      blue_d       = video_on_q ? BLUE_I  : 4'h0;
      h_sync_dly_d = h_sync_q;
      v_sync_dly_d = v_sync_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      red_q        <= 4'h0;
      green_q      <= 4'h0;
      blue_q       <= 4'h0;
      h_sync_dly_q <= 1'b1;
      v_sync_dly_q <= 1'b1;
    end else begin
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      h_sync_dly_q <= h_sync_dly_d;
      v_sync_dly_q <= v_sync_dly_d;
    end
  end

  assign VGA_RED_O    = red_q;
  assign VGA_GREEN_O  = green_q;
  assign VGA_BLUE_O   = blue_q;
  assign VGA_H_SYNC_O = h_sync_dly_q;
  assign VGA_V_SYNC_O = v_sync_dly_q;
`else
  assign VGA_H_SYNC_O = h_sync_q;
  assign VGA_V_SYNC_O = v_sync_q;
`endif

endmodule
